// File: rtl/cordic_pipe_pkg.sv
// Shared definitions for the CORDIC elastic pipeline blocks.
//   skid_mode_e : selects how in_ready is produced (combinational or registered
//                 through a 1-entry input skid buffer).
//   occ_w()     : width of an occupancy counter for a given stage count; it leaves
//                 room for every stage plus one skid entry.
package cordic_pipe_pkg;

    typedef enum int {
        SKID_COMB = 0,
        SKID_REG  = 1
    } skid_mode_e;

    function automatic int occ_w(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One register slot of the elastic pipeline: a valid bit plus a data word.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_flush    clears the valid bit (data is kept)
//   i_ld       slot takes the upstream value this cycle
//   i_v, i_d   upstream valid / data
//   o_v, o_d   registered valid / data of this slot
module elastic_pipe_stage
    import cordic_pipe_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int DATA_RST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_ld,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_v,
    output logic [WIDTH-1:0] o_d
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_v <= 1'b0;
        end else if (i_ld) begin
            r_v <= i_v;
        end
    end

    // NOTE: the data word carries no reset unless DATA_RST asks for it; the valid
    // bit alone defines whether the word means anything, and a reset-free flop is
    // cheaper. It only captures real items, so bubbles do not toggle it.
    always_ff @(posedge clk) begin
        if ((DATA_RST != 0) && rst) begin
            r_d <= '0;
        end else if (i_ld && i_v) begin
            r_d <= i_d;
        end
    end

    assign o_v = r_v;
    assign o_d = r_d;

endmodule

// File: rtl/elastic_pipe_chain.sv
// Elastic N-stage pipeline register chain with valid/ready handshake, used
// between CORDIC iteration stages. Empty stages always load, so bubbles collapse
// even while the output is stalled. With SKID=1 a 1-entry input skid buffer
// makes in_ready a register output.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 discards all in-flight data (valid bits only)
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake (last stage)
//   occupancy             registered count of valid stages plus skid entry
module elastic_pipe_chain
    import cordic_pipe_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int STAGES   = 4,
    parameter int SKID     = 1,
    parameter int DATA_RST = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [occ_w(STAGES)-1:0]     occupancy
);

    localparam int               OCC_W   = occ_w(STAGES);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(STAGES + SKID);

    logic                w_clear;
    logic [STAGES-1:0]   w_v;
    logic [WIDTH-1:0]    w_d [STAGES];
    logic [STAGES:0]     w_ld;
    logic                w_src_v;
    logic [WIDTH-1:0]    w_src_d;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [OCC_W-1:0]    r_occ;

    assign w_clear = rst || flush;

    // A stage loads when it is empty or when the stage after it moves on; the
    // last stage looks at out_ready. Walked from the output back to the input.
    // NOTE: w_ld gets a full default before the loop so no bit can hold its old
    // value and infer a latch.
    always_comb begin
        w_ld         = '0;
        w_ld[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_ld[i] = !w_v[i] || w_ld[i+1];
        end
    end

    if (SKID == int'(SKID_REG)) begin : g_skid
        logic             r_skid_v;
        logic [WIDTH-1:0] r_skid_d;
        logic             w_capture;

        // Capture only when the skid is empty, an item arrives and stage 0
        // cannot take it directly.
        assign w_capture = !r_skid_v && in_valid && !w_ld[0];

        always_ff @(posedge clk) begin
            if (w_clear) begin
                r_skid_v <= 1'b0;
            end else if (r_skid_v) begin
                if (w_ld[0]) begin
                    r_skid_v <= 1'b0;
                end
            end else if (w_capture) begin
                r_skid_v <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if ((DATA_RST != 0) && rst) begin
                r_skid_d <= '0;
            end else if (w_capture) begin
                r_skid_d <= in_data;
            end
        end

        // Registered ready; rst/flush only gate it so nothing is accepted in a
        // cycle whose state is being discarded.
        assign in_ready = !r_skid_v && !w_clear;
        // The skid, when full, is older than anything on in_*; in_valid cannot
        // be accepted then anyway since in_ready is low.
        assign w_src_v  = r_skid_v || in_valid;
        assign w_src_d  = r_skid_v ? r_skid_d : in_data;
    end else begin : g_no_skid
        assign in_ready = w_ld[0] && !w_clear;
        assign w_src_v  = in_valid;
        assign w_src_d  = in_data;
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             w_up_v;
        logic [WIDTH-1:0] w_up_d;

        if (i == 0) begin : g_first
            assign w_up_v = w_src_v;
            assign w_up_d = w_src_d;
        end else begin : g_next
            assign w_up_v = w_v[i-1];
            assign w_up_d = w_d[i-1];
        end

        elastic_pipe_stage #(
            .WIDTH    (WIDTH),
            .DATA_RST (DATA_RST)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush),
            .i_ld    (w_ld[i]),
            .i_v     (w_up_v),
            .i_d     (w_up_d),
            .o_v     (w_v[i]),
            .o_d     (w_d[i])
        );
    end

    // The mask keeps the discarded item from being handed downstream in the
    // flush/reset cycle itself.
    assign out_valid = w_v[STAGES-1] && !w_clear;
    assign out_data  = w_d[STAGES-1];

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            if (r_occ != OCC_MAX) begin
                r_occ <= r_occ + OCC_W'(1);
            end
        end else if (!w_in_xfer && w_out_xfer) begin
            if (r_occ != '0) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed bench for elastic_pipe_chain: DUT A (STAGES=4, SKID=1) for the
// latency/stall/bubble/flush/reset scenarios, DUT B (STAGES=1, SKID=0) for a
// long random run against a queue model.
module tb_elastic_pipe_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [19:0] a_in_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [19:0] a_out_data;
    logic [2:0]  a_occ;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_data;
    logic [1:0]  b_occ;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    elastic_pipe_chain #(
        .WIDTH(20), .STAGES(4), .SKID(1), .DATA_RST(0)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    elastic_pipe_chain #(
        .WIDTH(8), .STAGES(1), .SKID(0), .DATA_RST(1)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    // Inputs change on the falling edge; outputs are sampled 1 time unit later,
    // well clear of the rising edge.
    task automatic drive_a(input logic v, input logic [19:0] d, input logic rdy);
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low: got %b expected 0", a_in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid);
        end
        checks++;
        if (a_occ !== 3'd0) begin
            errors++; $display("FAIL reset_occupancy: got %0d expected 0", a_occ);
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready_high: got %b expected 1", a_in_ready);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_occ !== 2'd0 || b_out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_dut_b: got v=%b occ=%0d d=%h expected v=0 occ=0 d=00",
                     b_out_valid, b_occ, b_out_data);
        end
    endtask

    // Eight items back-to-back: first out_valid 4 cycles after first accept.
    task automatic test_stream();
        for (int c = 0; c < 16; c++) begin
            drive_a(c < 8, 20'(c + 1), 1'b1);
            if (c < 8) begin
                checks++;
                if (a_in_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, a_in_ready);
                end
            end
            checks++;
            if (c >= 4 && c < 12) begin
                if (a_out_valid !== 1'b1 || a_out_data !== 20'(c - 3)) begin
                    errors++;
                    $display("FAIL stream_out c=%0d: got v=%b d=%h expected v=1 d=%h",
                             c, a_out_valid, a_out_data, 20'(c - 3));
                end
            end else if (a_out_valid !== 1'b0) begin
                errors++; $display("FAIL stream_idle c=%0d: got v=%b expected 0", c, a_out_valid);
            end
        end
        checks++;
        if (a_occ !== 3'd0) begin
            errors++; $display("FAIL stream_occ_end: got %0d expected 0", a_occ);
        end
    endtask

    // Stalled output: four items fill the stages, the fifth lands in the skid,
    // the sixth is refused. Then drain.
    task automatic test_full();
        for (int c = 0; c < 7; c++) begin
            drive_a(1'b1, (c < 5) ? 20'(20'h11 + c) : 20'h16, 1'b0);
            checks++;
            if (a_in_ready !== (c < 5)) begin
                errors++;
                $display("FAIL full_in_ready c=%0d: got %b expected %b", c, a_in_ready, (c < 5));
            end
        end
        checks++;
        if (a_occ !== 3'd5) begin
            errors++; $display("FAIL full_occupancy: got %0d expected 5", a_occ);
        end
        for (int c = 7; c < 13; c++) begin
            drive_a(1'b0, 20'h0, 1'b1);
            if (c == 7 || c == 8) begin
                checks++;
                if (a_in_ready !== (c == 8)) begin
                    errors++;
                    $display("FAIL full_drain_ready c=%0d: got %b expected %b", c, a_in_ready, (c == 8));
                end
            end
            checks++;
            if (c < 12) begin
                if (a_out_valid !== 1'b1 || a_out_data !== 20'(20'h11 + c - 7)) begin
                    errors++;
                    $display("FAIL full_drain c=%0d: got v=%b d=%h expected v=1 d=%h",
                             c, a_out_valid, a_out_data, 20'(20'h11 + c - 7));
                end
            end else if (a_out_valid !== 1'b0 || a_occ !== 3'd0) begin
                errors++;
                $display("FAIL full_empty: got v=%b occ=%0d expected v=0 occ=0", a_out_valid, a_occ);
            end
        end
    endtask

    // A, two idle cycles, B, output stalled: B must catch up behind A.
    task automatic test_bubble();
        for (int c = 0; c < 9; c++) begin
            drive_a(c == 0 || c == 3, (c == 0) ? 20'hA : 20'hB, 1'b0);
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 20'hA || a_occ !== 3'd2) begin
            errors++;
            $display("FAIL bubble_stall: got v=%b d=%h occ=%0d expected v=1 d=0000a occ=2",
                     a_out_valid, a_out_data, a_occ);
        end
        drive_a(1'b0, 20'h0, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 20'hA) begin
            errors++; $display("FAIL bubble_out_a: got v=%b d=%h expected v=1 d=0000a", a_out_valid, a_out_data);
        end
        drive_a(1'b0, 20'h0, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 20'hB) begin
            errors++; $display("FAIL bubble_out_b: got v=%b d=%h expected v=1 d=0000b", a_out_valid, a_out_data);
        end
        drive_a(1'b0, 20'h0, 1'b1);
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 3'd0) begin
            errors++; $display("FAIL bubble_empty: got v=%b occ=%0d expected v=0 occ=0", a_out_valid, a_occ);
        end
    endtask

    // Three items parked with the oldest at the output, then flush with
    // in_valid=1 and out_ready=1.
    task automatic test_flush();
        for (int c = 0; c < 4; c++) begin
            drive_a(c < 3, 20'(20'h31 + c), 1'b0);
        end
        @(negedge clk);
        flush = 1'b1; a_in_valid = 1'b1; a_in_data = 20'h3F; a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_occ !== 3'd3) begin
            errors++;
            $display("FAIL flush_cycle: got v=%b rdy=%b occ=%0d expected v=0 rdy=0 occ=3",
                     a_out_valid, a_in_ready, a_occ);
        end
        @(negedge clk);
        flush = 1'b0; a_in_valid = 1'b1; a_in_data = 20'h40; a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 3'd0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: got v=%b occ=%0d rdy=%b expected v=0 occ=0 rdy=1",
                     a_out_valid, a_occ, a_in_ready);
        end
        for (int c = 6; c < 11; c++) begin
            drive_a(1'b0, 20'h0, 1'b1);
            checks++;
            if (a_out_valid !== (c == 9) || (c == 9 && a_out_data !== 20'h40)) begin
                errors++;
                $display("FAIL flush_resume c=%0d: got v=%b d=%h expected v=%b d=00040",
                         c, a_out_valid, a_out_data, (c == 9));
            end
        end
    endtask

    task automatic test_rst_mid();
        drive_a(1'b1, 20'h51, 1'b0);
        drive_a(1'b1, 20'h52, 1'b0);
        @(negedge clk);
        rst = 1'b1; a_in_valid = 1'b1; a_in_data = 20'h53;
        #1;
        checks++;
        if (a_in_ready !== 1'b0 || a_occ !== 3'd2) begin
            errors++;
            $display("FAIL rst_mid_cycle: got rdy=%b occ=%0d expected rdy=0 occ=2", a_in_ready, a_occ);
        end
        @(negedge clk);
        rst = 1'b0; a_in_valid = 1'b1; a_in_data = 20'h54; a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 3'd0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after: got v=%b occ=%0d rdy=%b expected v=0 occ=0 rdy=1",
                     a_out_valid, a_occ, a_in_ready);
        end
        for (int c = 4; c < 9; c++) begin
            drive_a(1'b0, 20'h0, 1'b1);
            checks++;
            if (a_out_valid !== (c == 7) || (c == 7 && a_out_data !== 20'h54)) begin
                errors++;
                $display("FAIL rst_mid_resume c=%0d: got v=%b d=%h expected v=%b d=00054",
                         c, a_out_valid, a_out_data, (c == 7));
            end
        end
    endtask

    // Single stage, combinational ready: random traffic against a queue model.
    task automatic test_random();
        logic [7:0] q[$];
        logic       exp_ov;
        logic       exp_ir;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_data   = 8'($urandom);
            #1;
            exp_ov = (q.size() != 0);
            exp_ir = (q.size() == 0) || b_out_ready;
            checks++;
            if (b_out_valid !== exp_ov || b_in_ready !== exp_ir || b_occ !== 2'(q.size())) begin
                errors++;
                if (errors < 20)
                    $display("FAIL rand_ctrl n=%0d: got v=%b rdy=%b occ=%0d expected v=%b rdy=%b occ=%0d",
                             n, b_out_valid, b_in_ready, b_occ, exp_ov, exp_ir, q.size());
            end
            if (exp_ov) begin
                checks++;
                if (b_out_data !== q[0]) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL rand_data n=%0d: got %h expected %h", n, b_out_data, q[0]);
                end
                if (b_out_ready) void'(q.pop_front());
            end
            if (b_in_valid && exp_ir) q.push_back(b_in_data);
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_bubble();
        test_flush();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
